pc_unit: RTL and testbench

- Parametrised program-counter unit for the 2A03 core; successor to the simple PC register.
- Holds the PC and performs increment and byte loads.
- Adds relative branches with 6502-accurate page-cross fix-up cycle, and a vector-fetch sequencer for reset/NMI/IRQ that reads the two vector bytes over a ready/ack handshake.
- Sits between the control unit (requests), the ALU/data bus (byte inputs) and the memory interface (vector reads).

---
 rtl/pc_unit.sv | 183 ++++++++++++++++++
 tb/tb_pc_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program-counter unit for the 2A03 core.
//
// Holds the PC and performs increment, byte loads and relative branches. A
// branch that crosses a page costs one extra cycle (BR_FIX), as on a real
// 6502. A small sequencer fetches the reset/NMI/IRQ vector as two byte reads
// over a ready/ack handshake.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   inc           PC += 1
//   load_l/load_h load PC[7:0] from lo_in / PC[WIDTH-1:8] from hi_in
//   branch_req    PC += sign-extended branch_off
//   vec_req       start a vector fetch for vector vec_sel
//                 (0=NMI, 1=reset, 2/3=IRQ/BRK)
//   mem_data      vector byte, valid when mem_ack=1
//   vec_addr      address of the vector byte being read
//   vec_rd        vector read request
//   pc_out        current PC
//   busy          unit not idle; requests are ignored while set
//   page_cross    one-cycle pulse: the last branch crossed a page
//   vec_done      one-cycle pulse: vector fetch complete
//
// Request priority in IDLE: vec_req > branch_req > load_l/load_h > inc.
// Lower-priority requests in the same cycle are dropped.
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int          WIDTH    = 16,
    parameter logic [15:0] VEC_BASE = 16'hFFFA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load_l,
    input  logic             load_h,
    input  logic [7:0]       lo_in,
    input  logic [WIDTH-9:0] hi_in,
    input  logic             branch_req,
    input  logic [7:0]       branch_off,
    input  logic             vec_req,
    input  logic [1:0]       vec_sel,
    input  logic [7:0]       mem_data,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] vec_addr,
    output logic             vec_rd,
    output logic [WIDTH-1:0] pc_out,
    output logic             busy,
    output logic             page_cross,
    output logic             vec_done
);

    localparam int         HW        = WIDTH - 8;
    localparam logic [1:0] SEL_RESET = 2'd1;

    typedef enum logic [2:0] {
        RST_HOLD,
        VEC_LO,
        VEC_HI,
        IDLE,
        BR_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q;
    logic [1:0]       sel_q;
    logic             br_neg_q;
    logic             page_cross_q;
    logic             vec_done_q;

    logic [8:0]       br_sum;
    logic             br_cross;
    logic [15:0]      vec_base_sel;

    // The 9th bit of the low-byte sum is the page carry. A positive offset
    // crosses when it carries; a negative offset (whose sign extension is
    // all ones in the high part) crosses when it does NOT carry.
    assign br_sum   = {1'b0, pc_q[7:0]} + {1'b0, branch_off};
    assign br_cross = branch_off[7] ? ~br_sum[8] : br_sum[8];

    always_comb begin
        unique case (sel_q)
            2'd0:    vec_base_sel = VEC_BASE;
            2'd1:    vec_base_sel = VEC_BASE + 16'd2;
            default: vec_base_sel = VEC_BASE + 16'd4;
        endcase
    end

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // flop samples its inputs from before the edge, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RST_HOLD;
        else     state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RST_HOLD: state_d = VEC_LO;
            VEC_LO:   if (mem_ack) state_d = VEC_HI;
            VEC_HI:   if (mem_ack) state_d = IDLE;
            IDLE: begin
                if (vec_req)                     state_d = VEC_LO;
                else if (branch_req && br_cross) state_d = BR_FIX;
            end
            BR_FIX:   state_d = IDLE;
            default:  state_d = RST_HOLD;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        vec_rd   = 1'b0;
        busy     = (state_q != IDLE);
        vec_addr = '0;
        unique case (state_q)
            VEC_LO: begin
                vec_rd   = 1'b1;
                vec_addr = WIDTH'(vec_base_sel);
            end
            VEC_HI: begin
                vec_rd   = 1'b1;
                vec_addr = WIDTH'(vec_base_sel + 16'd1);
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            sel_q        <= SEL_RESET;
            br_neg_q     <= 1'b0;
            page_cross_q <= 1'b0;
            vec_done_q   <= 1'b0;
        end else begin
            page_cross_q <= 1'b0;
            vec_done_q   <= 1'b0;
            unique case (state_q)
                RST_HOLD: sel_q <= SEL_RESET;
                VEC_LO: begin
                    if (mem_ack) pc_q[7:0] <= mem_data;
                end
                VEC_HI: begin
                    if (mem_ack) begin
                        // Vector high byte is zero-extended: bits above 15 clear.
                        pc_q[WIDTH-1:8] <= HW'(mem_data);
                        vec_done_q      <= 1'b1;
                    end
                end
                IDLE: begin
                    if (vec_req) begin
                        sel_q <= vec_sel;
                    end else if (branch_req) begin
                        pc_q[7:0]    <= br_sum[7:0];
                        br_neg_q     <= branch_off[7];
                        page_cross_q <= br_cross;
                    end else if (load_l || load_h) begin
                        if (load_l) pc_q[7:0]       <= lo_in;
                        if (load_h) pc_q[WIDTH-1:8] <= hi_in;
                    end else if (inc) begin
                        pc_q <= pc_q + WIDTH'(1);
                    end
                end
                BR_FIX: begin
                    // Fix up the high part after the low byte already moved.
                    if (br_neg_q) pc_q[WIDTH-1:8] <= pc_q[WIDTH-1:8] - HW'(1);
                    else          pc_q[WIDTH-1:8] <= pc_q[WIDTH-1:8] + HW'(1);
                end
                default: ;
            endcase
        end
    end

    assign pc_out     = pc_q;
    assign page_cross = page_cross_q;
    assign vec_done   = vec_done_q;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit (WIDTH=16, VEC_BASE=FFFA).
// Single-cycle IDLE operations run from a table through a scoreboard queue;
// reset, vector fetches and priority rules are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        inc, load_l, load_h;
    logic [7:0]  lo_in, hi_in;
    logic        branch_req;
    logic [7:0]  branch_off;
    logic        vec_req;
    logic [1:0]  vec_sel;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic [15:0] vec_addr;
    logic        vec_rd;
    logic [15:0] pc_out;
    logic        busy, page_cross, vec_done;

    int n_checks = 0;
    int n_pass   = 0;

    pc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc),
        .load_l     (load_l),
        .load_h     (load_h),
        .lo_in      (lo_in),
        .hi_in      (hi_in),
        .branch_req (branch_req),
        .branch_off (branch_off),
        .vec_req    (vec_req),
        .vec_sel    (vec_sel),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .vec_addr   (vec_addr),
        .vec_rd     (vec_rd),
        .pc_out     (pc_out),
        .busy       (busy),
        .page_cross (page_cross),
        .vec_done   (vec_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        inc, ld_l, ld_h, br;
        logic [7:0]  lo, hi, off;
        logic [15:0] pc;
        logic        bsy, pcx;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        bsy, pcx;
    } exp_t;

    vec_t tv[$];
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input logic i, ll, lh, b,
                       input logic [7:0] lo, hi, off,
                       input logic [15:0] pc, input logic bs, px);
        vec_t v;
        v.name = n; v.inc = i; v.ld_l = ll; v.ld_h = lh; v.br = b;
        v.lo = lo; v.hi = hi; v.off = off; v.pc = pc; v.bsy = bs; v.pcx = px;
        tv.push_back(v);
    endtask

    task automatic idle_inputs();
        inc = 0; load_l = 0; load_h = 0; branch_req = 0; vec_req = 0;
        mem_ack = 0;
    endtask

    // DUT must already be in VEC_LO. Supplies lo/hi with wait cycles; during
    // high-byte wait cycles an inc is asserted that must be ignored.
    task automatic vec_fetch(input string n, input logic [15:0] base,
                             input logic [7:0] lo, hi,
                             input int wait_lo, wait_hi,
                             input logic [15:0] pc_before);
        int done_cnt;
        done_cnt = 0;
        check({n, " vec_rd lo"}, vec_rd, 1);
        check({n, " addr lo"}, vec_addr, base);
        check({n, " busy lo"}, busy, 1);
        for (int i = 0; i < wait_lo; i++) begin
            tick();
            if (vec_done) done_cnt++;
            check({n, " addr lo wait"}, vec_addr, base);
            check({n, " pc lo wait"}, pc_out, pc_before);
        end
        mem_data = lo; mem_ack = 1;
        tick();
        mem_ack = 0;
        if (vec_done) done_cnt++;
        check({n, " addr hi"}, vec_addr, base + 16'd1);
        check({n, " pc lo byte"}, pc_out, {pc_before[15:8], lo});
        for (int i = 0; i < wait_hi; i++) begin
            inc = 1;
            tick();
            inc = 0;
            if (vec_done) done_cnt++;
            check({n, " inc ignored"}, pc_out, {pc_before[15:8], lo});
            check({n, " addr hi wait"}, vec_addr, base + 16'd1);
        end
        mem_data = hi; mem_ack = 1;
        tick();
        mem_ack = 0;
        check({n, " pc"}, pc_out, {hi, lo});
        check({n, " vec_done"}, vec_done, 1);
        check({n, " busy end"}, busy, 0);
        check({n, " vec_rd end"}, vec_rd, 0);
        tick();
        if (vec_done) done_cnt++;
        check({n, " vec_done once"}, done_cnt, 0);
    endtask

    initial begin
        exp_t e;
        rst = 1; idle_inputs();
        lo_in = 0; hi_in = 0; branch_off = 0; vec_sel = 0; mem_data = 0;

        // ---------------- power-on reset and boot fetch ----------------
        tick(); tick();
        check("rst pc", pc_out, 16'h0000);
        check("rst busy", busy, 1);
        check("rst vec_rd", vec_rd, 0);
        check("rst vec_addr", vec_addr, 16'h0000);
        check("rst page_cross", page_cross, 0);
        check("rst vec_done", vec_done, 0);
        rst = 0;
        tick();
        vec_fetch("boot", 16'hFFFC, 8'h34, 8'h12, 0, 0, 16'h0000);

        // ---------------- table: one IDLE edge per row ----------------
        //   name          inc ll lh br  lo     hi     off    pc        bsy pcx
        add("load+inc",    1, 1, 1, 0, 8'hFF, 8'hFF, 8'h00, 16'hFFFF, 0, 0);
        add("inc wrap",    1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0);
        add("load 1210",   0, 1, 1, 0, 8'h10, 8'h12, 8'h00, 16'h1210, 0, 0);
        add("br +05",      0, 0, 0, 1, 8'h00, 8'h00, 8'h05, 16'h1215, 0, 0);
        add("load 12F0",   0, 1, 1, 0, 8'hF0, 8'h12, 8'h00, 16'h12F0, 0, 0);
        add("br +20 e1",   0, 0, 0, 1, 8'h00, 8'h00, 8'h20, 16'h1210, 1, 1);
        add("br +20 e2",   0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 16'h1310, 0, 0);
        add("load 0005",   0, 1, 1, 0, 8'h05, 8'h00, 8'h00, 16'h0005, 0, 0);
        add("br -16 e1",   0, 0, 0, 1, 8'h00, 8'h00, 8'hF0, 16'h00F5, 1, 1);
        add("br -16 e2",   1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 16'hFFF5, 0, 0);
        add("load_l only", 0, 1, 0, 0, 8'h80, 8'h00, 8'h00, 16'hFF80, 0, 0);
        add("load_h only", 0, 0, 1, 0, 8'h00, 8'hAB, 8'h00, 16'hAB80, 0, 0);
        add("br+inc +7F",  1, 0, 0, 1, 8'h00, 8'h00, 8'h7F, 16'hABFF, 0, 0);
        add("br +01 e1",   0, 0, 0, 1, 8'h00, 8'h00, 8'h01, 16'hAB00, 1, 1);
        add("br +01 e2",   0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 16'hAC00, 0, 0);
        add("br -01 e1",   0, 0, 0, 1, 8'h00, 8'h00, 8'hFF, 16'hACFF, 1, 1);
        add("br -01 e2",   0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 16'hABFF, 0, 0);
        add("br -128",     0, 1, 1, 1, 8'h11, 8'h22, 8'h80, 16'hAB7F, 0, 0);
        add("inc",         1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 16'hAB80, 0, 0);

        foreach (tv[i]) begin
            inc = tv[i].inc; load_l = tv[i].ld_l; load_h = tv[i].ld_h;
            branch_req = tv[i].br; lo_in = tv[i].lo; hi_in = tv[i].hi;
            branch_off = tv[i].off;
            e.name = tv[i].name; e.pc = tv[i].pc; e.bsy = tv[i].bsy; e.pcx = tv[i].pcx;
            exp_q.push_back(e);
            tick();
            idle_inputs();
            e = exp_q.pop_front();
            check({e.name, " pc"}, pc_out, e.pc);
            check({e.name, " busy"}, busy, e.bsy);
            check({e.name, " page_cross"}, page_cross, e.pcx);
        end
        check("scoreboard empty", exp_q.size(), 0);

        // ---------------- async reset in BR_FIX, fetch with wait ----------------
        load_l = 1; load_h = 1; lo_in = 8'hF0; hi_in = 8'h12;
        tick();
        idle_inputs();
        branch_req = 1; branch_off = 8'h20;
        tick();
        idle_inputs();
        check("pre-rst busy", busy, 1);
        check("pre-rst page_cross", page_cross, 1);
        #2 rst = 1;
        #1;
        check("async rst pc", pc_out, 16'h0000);
        check("async rst busy", busy, 1);
        check("async rst page_cross", page_cross, 0);
        check("async rst vec_rd", vec_rd, 0);
        check("async rst vec_addr", vec_addr, 16'h0000);
        tick();
        rst = 0;
        check("rst hold vec_rd", vec_rd, 0);
        tick();
        vec_fetch("refetch", 16'hFFFC, 8'h34, 8'h12, 2, 0, 16'h0000);

        // ---------------- priority: vec_req beats branch and inc ----------------
        vec_req = 1; vec_sel = 2'd0; branch_req = 1; branch_off = 8'h05; inc = 1;
        tick();
        idle_inputs();
        check("prio pc", pc_out, 16'h1234);
        check("prio page_cross", page_cross, 0);
        vec_fetch("nmi", 16'hFFFA, 8'hCD, 8'hAB, 0, 2, 16'h1234);

        // IRQ/BRK through selector 3
        vec_req = 1; vec_sel = 2'd3;
        tick();
        idle_inputs();
        vec_fetch("irq", 16'hFFFE, 8'h78, 8'h56, 1, 0, 16'hABCD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
